// File: rtl/mc97_pkg.sv
// Shared definitions for the MC97 register access path: FSM encoding,
// register bus widths and the latched request payload.
package mc97_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } reg_req_t;

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit saturating event counter; clear wins over a same-cycle increment.
module sat_cnt8
    import mc97_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mc97_reg_ctrl.sv
// Host-side codec register access engine: holds one request toward the MC97
// link until acknowledged, retries failed reads and aborts on a dead bit clock.
module mc97_reg_ctrl
    import mc97_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 200000,
    parameter int unsigned TW        = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_we,
    input  logic              bus_req,
    output logic              bus_busy,
    output logic              bus_done,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err,
    output logic              bus_timeout,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_valid,
    input  logic              reg_ack,
    input  logic              reg_rerr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [CNT_W-1:0]  stat_rerr_cnt,
    output logic [CNT_W-1:0]  stat_fail_cnt,
    input  logic              stat_clr
);

    state_t            state, state_next;
    reg_req_t          req, req_next;
    logic [CNT_W-1:0]  retry_cnt, retry_next;
    logic [TW-1:0]     tmo_cnt, tmo_next;
    logic [DATA_W-1:0] rdata_next;
    logic              err_next, timeout_next;
    logic              rerr_inc, fail_inc;

    // State and all registered outputs, updated from the next-state process
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req         <= '0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            bus_rdata   <= '0;
            bus_err     <= 1'b0;
            bus_timeout <= 1'b0;
            bus_busy    <= 1'b0;
            bus_done    <= 1'b0;
            reg_valid   <= 1'b0;
        end else begin
            state       <= state_next;
            req         <= req_next;
            retry_cnt   <= retry_next;
            tmo_cnt     <= tmo_next;
            bus_rdata   <= rdata_next;
            bus_err     <= err_next;
            bus_timeout <= timeout_next;
            bus_busy    <= (state_next == ISSUE) || (state_next == GAP);
            bus_done    <= (state_next == DONE);
            reg_valid   <= (state_next == ISSUE);
        end
    end

    always_comb begin
        state_next   = state;
        req_next     = req;
        retry_next   = retry_cnt;
        tmo_next     = tmo_cnt;
        rdata_next   = bus_rdata;
        err_next     = bus_err;
        timeout_next = bus_timeout;
        rerr_inc     = 1'b0;
        fail_inc     = 1'b0;

        case (state)
            IDLE: begin
                if (bus_req) begin
                    req_next     = '{addr: bus_addr, wdata: bus_wdata, we: bus_we};
                    retry_next   = '0;
                    tmo_next     = '0;
                    err_next     = 1'b0;
                    timeout_next = 1'b0;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                tmo_next = tmo_cnt + TW'(1);
                if (reg_ack) begin
                    if (req.we) begin
                        state_next = DONE;
                    end else if (!reg_rerr) begin
                        rdata_next = reg_rdata;
                        state_next = DONE;
                    end else begin
                        rerr_inc = 1'b1;
                        if (retry_cnt < CNT_W'(MAX_RETRY)) begin
                            retry_next = retry_cnt + CNT_W'(1);
                            state_next = GAP;
                        end else begin
                            err_next   = 1'b1;
                            fail_inc   = 1'b1;
                            state_next = DONE;
                        end
                    end
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    // Ack takes precedence; only a silent link reaches here
                    err_next     = 1'b1;
                    timeout_next = 1'b1;
                    fail_inc     = 1'b1;
                    state_next   = DONE;
                end
            end
            GAP: begin
                tmo_next   = '0;
                state_next = ISSUE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign reg_addr  = req.addr;
    assign reg_wdata = req.wdata;
    assign reg_we    = req.we;

    sat_cnt8 u_rerr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rerr_inc),
        .clr   (stat_clr),
        .value (stat_rerr_cnt)
    );

    sat_cnt8 u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fail_inc),
        .clr   (stat_clr),
        .value (stat_fail_cnt)
    );

endmodule
